// File: rtl/hsv_pkg.sv
// Shared constants, sector encoding and hue helpers for the HSV-to-RGB pipeline.
package hsv_pkg;

   localparam int HUE_MOD    = 360;
   localparam int PCT_MAX    = 100;
   localparam int SECTOR_DEG = 60;
   localparam int OUT_MAX    = 255;

   localparam int IN_W    = 9;
   localparam int OUT_W   = 8;
   localparam int PCT_W   = 7;
   localparam int FRAC_W  = 6;
   localparam int LATENCY = 4;

   localparam int MAXPROD_W  = 15;
   localparam int MINPROD_W  = 22;
   localparam int STEPPROD_W = 14;

   typedef enum logic [2:0] {
      SEC_R_G = 3'd0,
      SEC_Y_G = 3'd1,
      SEC_G_B = 3'd2,
      SEC_C_B = 3'd3,
      SEC_B_M = 3'd4,
      SEC_M_R = 3'd5
   } sector_t;

   // Compare chain on a wrapped hue (0..359); avoids a divider.
   function automatic sector_t hue_sector(input logic [IN_W-1:0] h);
      if (h < IN_W'(SECTOR_DEG))          return SEC_R_G;
      else if (h < IN_W'(2 * SECTOR_DEG)) return SEC_Y_G;
      else if (h < IN_W'(3 * SECTOR_DEG)) return SEC_G_B;
      else if (h < IN_W'(4 * SECTOR_DEG)) return SEC_C_B;
      else if (h < IN_W'(5 * SECTOR_DEG)) return SEC_B_M;
      else                                return SEC_M_R;
   endfunction

   function automatic logic [IN_W-1:0] sector_base(input sector_t sec);
      logic [IN_W-1:0] base;
      base = '0;
      case (sec)
         SEC_R_G: base = IN_W'(0);
         SEC_Y_G: base = IN_W'(SECTOR_DEG);
         SEC_G_B: base = IN_W'(2 * SECTOR_DEG);
         SEC_C_B: base = IN_W'(3 * SECTOR_DEG);
         SEC_B_M: base = IN_W'(4 * SECTOR_DEG);
         SEC_M_R: base = IN_W'(5 * SECTOR_DEG);
         default: base = '0;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/hsv_const_div.sv
// Registered unsigned divide by a constant with a rounding offset: quo = (num + OFFSET) / DIVISOR.
module hsv_const_div #(
   parameter int          NUM_W   = 16,
   parameter int          Q_W     = 8,
   parameter int unsigned DIVISOR = 100,
   parameter int unsigned OFFSET  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NUM_W-1:0] num,
   output logic [Q_W-1:0]   quo
);

   // NUM_W is sized by the caller so that num + OFFSET never wraps.
   logic [NUM_W-1:0] biased;

   always_comb begin
      biased = num + NUM_W'(OFFSET);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo <= '0;
      end else begin
         quo <= Q_W'(biased / NUM_W'(DIVISOR));
      end
   end

endmodule

// File: rtl/hsv_to_rgb_pipe.sv
// Four-stage integer HSV-to-RGB converter: sanitise/sector, max/min, step, sector mux.
module hsv_to_rgb_pipe
   import hsv_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  Hue,
   input  logic [IN_W-1:0]  Saturation,
   input  logic [IN_W-1:0]  Value,
   output logic             out_valid,
   output logic [OUT_W-1:0] R,
   output logic [OUT_W-1:0] G,
   output logic [OUT_W-1:0] B
);

   logic [LATENCY-1:0] valid_sr;

   logic [IN_W-1:0]  hue_wrap;
   logic [PCT_W-1:0] sat_clip;
   logic [PCT_W-1:0] val_clip;
   sector_t          sector_in;

   sector_t          sec_s1;
   logic [FRAC_W-1:0] frac_s1;
   logic [PCT_W-1:0] sat_s1;
   logic [PCT_W-1:0] val_s1;

   logic [MAXPROD_W-1:0] max_num;
   logic [MINPROD_W-1:0] min_num;
   logic [OUT_W-1:0]     max_s2;
   logic [OUT_W-1:0]     min_s2;
   sector_t              sec_s2;
   logic [FRAC_W-1:0]    frac_s2;

   logic [OUT_W-1:0]      span;
   logic [STEPPROD_W-1:0] step_num;
   logic [OUT_W-1:0]      step_s3;
   logic [OUT_W-1:0]      max_s3;
   logic [OUT_W-1:0]      min_s3;
   sector_t               sec_s3;

   logic [OUT_W-1:0] rise;
   logic [OUT_W-1:0] fall;
   logic [OUT_W-1:0] r_nxt;
   logic [OUT_W-1:0] g_nxt;
   logic [OUT_W-1:0] b_nxt;

   // Out-of-range inputs are folded back rather than rejected.
   always_comb begin
      hue_wrap  = (Hue >= IN_W'(HUE_MOD)) ? Hue - IN_W'(HUE_MOD) : Hue;
      sat_clip  = (Saturation > IN_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : Saturation[PCT_W-1:0];
      val_clip  = (Value > IN_W'(PCT_MAX)) ? PCT_W'(PCT_MAX) : Value[PCT_W-1:0];
      sector_in = hue_sector(hue_wrap);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_sr <= '0;
         sec_s1   <= SEC_R_G;
         frac_s1  <= '0;
         sat_s1   <= '0;
         val_s1   <= '0;
      end else begin
         valid_sr <= {valid_sr[LATENCY-2:0], in_valid};
         sec_s1   <= sector_in;
         frac_s1  <= FRAC_W'(hue_wrap - sector_base(sector_in));
         sat_s1   <= sat_clip;
         val_s1   <= val_clip;
      end
   end

   always_comb begin
      max_num = MAXPROD_W'(val_s1) * MAXPROD_W'(OUT_MAX);
      min_num = MINPROD_W'(val_s1) * MINPROD_W'(PCT_W'(PCT_MAX) - sat_s1) * MINPROD_W'(OUT_MAX);
   end

   hsv_const_div #(
      .NUM_W   (MAXPROD_W),
      .Q_W     (OUT_W),
      .DIVISOR (PCT_MAX),
      .OFFSET  (PCT_MAX / 2)
   ) u_max_div (
      .clk   (clk),
      .reset (reset),
      .num   (max_num),
      .quo   (max_s2)
   );

   hsv_const_div #(
      .NUM_W   (MINPROD_W),
      .Q_W     (OUT_W),
      .DIVISOR (PCT_MAX * PCT_MAX),
      .OFFSET  (PCT_MAX * PCT_MAX / 2)
   ) u_min_div (
      .clk   (clk),
      .reset (reset),
      .num   (min_num),
      .quo   (min_s2)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_s2  <= SEC_R_G;
         frac_s2 <= '0;
      end else begin
         sec_s2  <= sec_s1;
         frac_s2 <= frac_s1;
      end
   end

   // min never exceeds max, so the span cannot underflow.
   always_comb begin
      span     = max_s2 - min_s2;
      step_num = STEPPROD_W'(span) * STEPPROD_W'(frac_s2);
   end

   hsv_const_div #(
      .NUM_W   (STEPPROD_W),
      .Q_W     (OUT_W),
      .DIVISOR (SECTOR_DEG),
      .OFFSET  (SECTOR_DEG / 2)
   ) u_step_div (
      .clk   (clk),
      .reset (reset),
      .num   (step_num),
      .quo   (step_s3)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_s3 <= SEC_R_G;
         max_s3 <= '0;
         min_s3 <= '0;
      end else begin
         sec_s3 <= sec_s2;
         max_s3 <= max_s2;
         min_s3 <= min_s2;
      end
   end

   always_comb begin
      rise  = min_s3 + step_s3;
      fall  = max_s3 - step_s3;
      r_nxt = max_s3;
      g_nxt = rise;
      b_nxt = min_s3;
      case (sec_s3)
         SEC_R_G: begin r_nxt = max_s3; g_nxt = rise;   b_nxt = min_s3; end
         SEC_Y_G: begin r_nxt = fall;   g_nxt = max_s3; b_nxt = min_s3; end
         SEC_G_B: begin r_nxt = min_s3; g_nxt = max_s3; b_nxt = rise;   end
         SEC_C_B: begin r_nxt = min_s3; g_nxt = fall;   b_nxt = max_s3; end
         SEC_B_M: begin r_nxt = rise;   g_nxt = min_s3; b_nxt = max_s3; end
         SEC_M_R: begin r_nxt = max_s3; g_nxt = min_s3; b_nxt = fall;   end
         default: begin r_nxt = max_s3; g_nxt = rise;   b_nxt = min_s3; end
      endcase
   end

   // Outputs only move with a valid result so the PWM stage can read them continuously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         R <= '0;
         G <= '0;
         B <= '0;
      end else if (valid_sr[LATENCY-2]) begin
         R <= r_nxt;
         G <= g_nxt;
         B <= b_nxt;
      end
   end

   assign out_valid = valid_sr[LATENCY-1];

endmodule
